// File: rtl/mul_sequencer.sv
// Iterative 32x32 shift-add multiplier sequencer (MUL/UMULL/SMULL) for the DPUS multiply path.
// Optional macro MUL_SEQ_EARLY_TERM_EN: leave CALC as soon as the remaining multiplier is zero.
module mul_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [3:0]  MulOp,
   input  logic [31:0] SrcA,
   input  logic [31:0] SrcB,
   output logic        Busy,
   output logic        Done,
   output logic        AuxW,
   output logic [31:0] ResultLo,
   output logic [31:0] ResultHi
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   localparam logic [3:0] OP_MUL   = 4'b0100;
   localparam logic [3:0] OP_UMULL = 4'b0101;
   localparam logic [3:0] OP_SMULL = 4'b0111;

   state_t      state_q, state_d;
   logic [63:0] acc_q, acc_d;
   logic [63:0] mcand_q, mcand_d;
   logic [31:0] mplier_q, mplier_d;
   logic [5:0]  count_q, count_d;
   logic        sign_q, sign_d;
   logic        isLong_q, isLong_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        auxW_q, auxW_d;
   logic [31:0] resLo_q, resLo_d;
   logic [31:0] resHi_q, resHi_d;

   logic        startValid;
   logic        isSigned;
   logic [31:0] magA, magB;
   logic [63:0] accStep, accFixed;

   assign startValid = Start && ((MulOp == OP_MUL) || (MulOp == OP_UMULL) || (MulOp == OP_SMULL));
   assign isSigned   = (MulOp == OP_SMULL);
   assign magA       = (isSigned && SrcA[31]) ? (~SrcA + 32'd1) : SrcA;
   assign magB       = (isSigned && SrcB[31]) ? (~SrcB + 32'd1) : SrcB;
   assign accStep    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
   assign accFixed   = sign_q ? (~acc_q + 64'd1) : acc_q;

   // Next-state and datapath control; a new request may be taken from IDLE or DONE.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      count_d  = count_q;
      sign_d   = sign_q;
      isLong_d = isLong_q;
      resLo_d  = resLo_q;
      resHi_d  = resHi_q;

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (startValid) begin
               state_d  = CALC;
               acc_d    = 64'd0;
               mcand_d  = {32'd0, magA};
               mplier_d = magB;
               count_d  = 6'd0;
               sign_d   = isSigned && (SrcA[31] ^ SrcB[31]);
               isLong_d = MulOp[0];
            end
         end
         CALC: begin
`ifdef MUL_SEQ_EARLY_TERM_EN
            if (mplier_q == 32'd0) begin
               state_d = FIX;
            end else begin
               acc_d    = accStep;
               mcand_d  = {mcand_q[62:0], 1'b0};
               mplier_d = {1'b0, mplier_q[31:1]};
               count_d  = count_q + 6'd1;
               if (count_q == 6'd31) state_d = FIX;
            end
`else
            acc_d    = accStep;
            mcand_d  = {mcand_q[62:0], 1'b0};
            mplier_d = {1'b0, mplier_q[31:1]};
            count_d  = count_q + 6'd1;
            if (count_q == 6'd31) state_d = FIX;
`endif
         end
         FIX: begin
            acc_d   = accFixed;
            resLo_d = accFixed[31:0];
            resHi_d = accFixed[63:32];
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy_d = (state_d == CALC) || (state_d == FIX);
   assign done_d = (state_d == DONE);
   assign auxW_d = (state_d == DONE) && isLong_d;

   // Reset aborts any operation in flight without issuing Done.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         acc_q    <= 64'd0;
         mcand_q  <= 64'd0;
         mplier_q <= 32'd0;
         count_q  <= 6'd0;
         sign_q   <= 1'b0;
         isLong_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         auxW_q   <= 1'b0;
         resLo_q  <= 32'd0;
         resHi_q  <= 32'd0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         count_q  <= count_d;
         sign_q   <= sign_d;
         isLong_q <= isLong_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         auxW_q   <= auxW_d;
         resLo_q  <= resLo_d;
         resHi_q  <= resHi_d;
      end
   end

   assign Busy     = busy_q;
   assign Done     = done_q;
   assign AuxW     = auxW_q;
   assign ResultLo = resLo_q;
   assign ResultHi = resHi_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed self-checking bench for mul_sequencer; expected latencies follow MUL_SEQ_EARLY_TERM_EN.
module tb_mul_sequencer;

   localparam logic [3:0] OP_MUL   = 4'b0100;
   localparam logic [3:0] OP_UMULL = 4'b0101;
   localparam logic [3:0] OP_SMULL = 4'b0111;

`ifdef MUL_SEQ_EARLY_TERM_EN
   localparam bit EarlyTerm = 1'b1;
`else
   localparam bit EarlyTerm = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        Start;
   logic [3:0]  MulOp;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        Busy;
   logic        Done;
   logic        AuxW;
   logic [31:0] ResultLo;
   logic [31:0] ResultHi;

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   mul_sequencer dut (
      .clk      (clk),
      .reset    (reset),
      .Start    (Start),
      .MulOp    (MulOp),
      .SrcA     (SrcA),
      .SrcB     (SrcB),
      .Busy     (Busy),
      .Done     (Done),
      .AuxW     (AuxW),
      .ResultLo (ResultLo),
      .ResultHi (ResultHi)
   );

   // 10 ns clock; the bench drives and samples on the falling edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Presents a request for one cycle; returns at the falling edge of cycle 1.
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      Start = 1'b1;
      MulOp = op;
      SrcA  = a;
      SrcB  = b;
      @(negedge clk);
      Start = 1'b0;
   endtask

   task automatic waitDone(input int startCycle, output int lat);
      lat = startCycle;
      while (Done !== 1'b1 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
   endtask

   int  lat;
   int  ignoredCycle;
   bit  doneSeen;

   initial begin
      reset = 1'b0;
      Start = 1'b0;
      MulOp = 4'd0;
      SrcA  = 32'd0;
      SrcB  = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      checkOutput("rstBusy", {63'd0, Busy}, 64'd0);
      checkOutput("rstDone", {63'd0, Done}, 64'd0);
      checkOutput("rstAuxW", {63'd0, AuxW}, 64'd0);
      checkOutput("rstResult", {ResultHi, ResultLo}, 64'd0);
      doneSeen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (Done !== 1'b0) doneSeen = 1'b1;
      end
      checkOutput("idleNoDone", {63'd0, doneSeen}, 64'd0);

      // An invalid op code must not start anything.
      applyStimulus(4'b0000, 32'd3, 32'd3);
      checkOutput("invalidBusy", {63'd0, Busy}, 64'd0);
      @(negedge clk);
      checkOutput("invalidBusy2", {63'd0, Busy}, 64'd0);

      applyStimulus(OP_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      checkOutput("umullBusy", {63'd0, Busy}, 64'd1);
      waitDone(1, lat);
      checkOutput("umullLat", 64'(lat), 64'd34);
      checkOutput("umullResult", {ResultHi, ResultLo}, 64'hFFFF_FFFE_0000_0001);
      checkOutput("umullAuxW", {63'd0, AuxW}, 64'd1);
      checkOutput("umullBusyDone", {63'd0, Busy}, 64'd0);
      @(negedge clk);
      checkOutput("umullDonePulse", {63'd0, Done}, 64'd0);
      checkOutput("umullAuxWPulse", {63'd0, AuxW}, 64'd0);
      checkOutput("umullHold", {ResultHi, ResultLo}, 64'hFFFF_FFFE_0000_0001);

      applyStimulus(OP_SMULL, 32'hFFFF_FFFF, 32'h0000_0002);
      waitDone(1, lat);
      checkOutput("smull1Lat", 64'(lat), EarlyTerm ? 64'd5 : 64'd34);
      checkOutput("smull1Result", {ResultHi, ResultLo}, 64'hFFFF_FFFF_FFFF_FFFE);
      checkOutput("smull1AuxW", {63'd0, AuxW}, 64'd1);
      @(negedge clk);

      applyStimulus(OP_SMULL, 32'h8000_0000, 32'h8000_0000);
      waitDone(1, lat);
      checkOutput("smull2Lat", 64'(lat), 64'd34);
      checkOutput("smull2Result", {ResultHi, ResultLo}, 64'h4000_0000_0000_0000);
      @(negedge clk);

      // MUL 7x6 with a stray Start mid-calculation, then a back-to-back request.
      ignoredCycle = EarlyTerm ? 3 : 10;
      applyStimulus(OP_MUL, 32'd7, 32'd6);
      repeat (ignoredCycle - 1) @(negedge clk);
      applyStimulus(OP_MUL, 32'd1, 32'd1);
      waitDone(ignoredCycle + 1, lat);
      checkOutput("mulLat", 64'(lat), EarlyTerm ? 64'd6 : 64'd34);
      checkOutput("mulResult", {ResultHi, ResultLo}, 64'h0000_0000_0000_002A);
      checkOutput("mulAuxW", {63'd0, AuxW}, 64'd0);
      applyStimulus(OP_MUL, 32'h0001_0000, 32'h0001_0000);
      checkOutput("b2bDoneDrop", {63'd0, Done}, 64'd0);
      checkOutput("b2bBusy", {63'd0, Busy}, 64'd1);
      waitDone(1, lat);
      checkOutput("b2bLat", 64'(lat), EarlyTerm ? 64'd20 : 64'd34);
      checkOutput("b2bResult", {ResultHi, ResultLo}, 64'h0000_0001_0000_0000);
      checkOutput("b2bAuxW", {63'd0, AuxW}, 64'd0);
      @(negedge clk);

      // Reset in the middle of a long operation.
      applyStimulus(OP_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (14) @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("midRstBusy", {63'd0, Busy}, 64'd0);
      checkOutput("midRstDone", {63'd0, Done}, 64'd0);
      checkOutput("midRstResult", {ResultHi, ResultLo}, 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("postRstIdle", {62'd0, Busy, Done}, 64'd0);
      applyStimulus(OP_UMULL, 32'd3, 32'd5);
      waitDone(1, lat);
      checkOutput("postRstLat", 64'(lat), EarlyTerm ? 64'd6 : 64'd34);
      checkOutput("postRstResult", {ResultHi, ResultLo}, 64'd15);
      checkOutput("postRstAuxW", {63'd0, AuxW}, 64'd1);
      @(negedge clk);

      applyStimulus(OP_UMULL, 32'd5, 32'd3);
      waitDone(1, lat);
      checkOutput("early5x3Lat", 64'(lat), EarlyTerm ? 64'd5 : 64'd34);
      checkOutput("early5x3Result", {ResultHi, ResultLo}, 64'd15);
      @(negedge clk);

      applyStimulus(OP_UMULL, 32'd9, 32'd0);
      waitDone(1, lat);
      checkOutput("early9x0Lat", 64'(lat), EarlyTerm ? 64'd3 : 64'd34);
      checkOutput("early9x0Result", {ResultHi, ResultLo}, 64'd0);
      checkOutput("early9x0AuxW", {63'd0, AuxW}, 64'd1);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Iterative multi-cycle multiplier controller for the DPUS multiply path. It accepts one MUL, UMULL or SMULL request from the multicycle control FSM. It sequences a single 64-bit shift-add datapath over up to 32 iterations and applies sign correction for SMULL. It returns a 64-bit result, with an auxiliary-write qualifier for the high word. It replaces the single-cycle combinational multiplier so the main FSM can stall on `Busy` instead of lengthening the critical path.

## Interface
- No parameters; datapath width fixed at 32-bit operands, 64-bit product.
- `clk` input 1: single clock, rising-edge.
- `reset` input 1: asynchronous, active-low (asserted when 0).
- `Start` input 1: request strobe, sampled each rising edge.
- `MulOp` input 4: DPUSControl encoding; 0100 MUL, 0101 UMULL, 0111 SMULL.
- `SrcA` input 32: multiplicand, sampled with accepted `Start`.
- `SrcB` input 32: multiplier, sampled with accepted `Start`.
- `Busy` output 1: operation in progress; the main FSM stalls while high.
- `Done` output 1: one-cycle pulse, result valid.
- `AuxW` output 1: high with `Done` only for UMULL/SMULL (write the high word to RdHi).
- `ResultLo` output 32: product bits [31:0].
- `ResultHi` output 32: product bits [63:32].

## Operation
- States: IDLE, CALC, FIX, DONE.
- **IDLE/DONE → CALC** on `Start` with a valid `MulOp`.
  - Latch the operand magnitudes: |SrcA|, |SrcB| for SMULL, raw values otherwise.
  - Latch the result sign: SrcA[31]^SrcB[31] for SMULL, 0 otherwise.
  - Latch the op; clear the 64-bit accumulator; clear the 6-bit iteration counter.
- **Start with an invalid MulOp**: ignored; stays in IDLE, or goes DONE → IDLE.
- **CALC**, one iteration per cycle:
  - If multiplier bit 0 = 1, add the 64-bit multiplicand to the accumulator.
  - Shift the multiplicand left by 1 and the multiplier right by 1 (logical); counter +1.
  - Exit to FIX after the iteration with counter = 31, i.e. 32 iterations.
- **FIX**:
  - If the sign bit is set, accumulator ← two's-complement negation (64-bit, wraps).
  - Load ResultHi/ResultLo from the accumulator.
- **DONE**:
  - `Done`=1; `AuxW`=1 iff op ∈ {UMULL, SMULL}.
  - Next state is CALC if `Start` is valid in this cycle, else IDLE.
- **MUL**: unsigned product; ResultHi holds the upper bits, `AuxW`=0.
- **Start while in CALC or FIX**: ignored; operands are not re-sampled.
- **Reset asserted (any state, including mid-CALC)**: immediately IDLE; all outputs 0; accumulator and counter cleared; no `Done` is issued for the aborted operation.
- **Reset values**: `Busy`=0, `Done`=0, `AuxW`=0, `ResultLo`=0, `ResultHi`=0.
- Results hold their last value until the next FIX.

## Timing
- Cycle 0: `Start` accepted (IDLE or DONE).
- Cycles 1..C: CALC, `Busy`=1.
- Cycle C+1: FIX, `Busy`=1.
- Cycle C+2: DONE, `Busy`=0, `Done`=1, results valid.
- C = 32 without early termination, so `Done` arrives in cycle 34.
- `Busy` is registered and rises in the cycle after `Start` is accepted. The main FSM treats an accepted `Start` plus `Busy` as stall.
- `Done`/`AuxW` are registered and high for exactly one cycle.
- Back-to-back: `Start` in the DONE cycle begins CALC in the next cycle, with no idle gap.

## Configuration
- Macro: `MUL_SEQ_EARLY_TERM_EN`.
- **Defined**: at the start of each CALC cycle, if the multiplier register is 0, skip the add and go to FIX.
  - C = min(k+1, 32), where k = bit position of the highest set bit of the latched multiplier magnitude, plus 1 (k=0 for zero).
  - SrcB=0 gives C=1, so `Done` arrives in cycle 3.
- **Undefined**: fixed C=32 regardless of operands; no zero-detect logic.

## Test plan
- **Reset**: hold `reset`=0 for 3 cycles, release → all outputs 0, `Busy`=0, no `Done` for 50 idle cycles.
- **UMULL full range**: SrcA=SrcB=0xFFFFFFFF, MulOp=0101 → cycle 34 (macro off): ResultHi=0xFFFFFFFE, ResultLo=0x00000001, `AuxW`=1, `Done` pulse 1 cycle.
- **SMULL signed**:
  - SrcA=0xFFFFFFFF, SrcB=0x00000002, MulOp=0111 → ResultHi=0xFFFFFFFF, ResultLo=0xFFFFFFFE, `AuxW`=1.
  - SrcA=SrcB=0x80000000 → ResultHi=0x40000000, ResultLo=0.
- **MUL with ignored Start**:
  - SrcA=7, SrcB=6, MulOp=0100 → ResultLo=0x0000002A, `AuxW`=0.
  - A second `Start` (SrcA=1, SrcB=1) pulsed in cycle 10 is ignored; the result is unchanged and `Done` fires only once.
  - A new `Start` in the DONE cycle → next `Done` exactly 34 cycles later.
- **Reset mid-operation**: UMULL started, `reset`=0 in cycle 15 → outputs 0 immediately. Release and issue UMULL 3×5 → ResultLo=15, ResultHi=0.
- **Early termination**:
  - With `MUL_SEQ_EARLY_TERM_EN`: UMULL 5×3 → `Done` in cycle 5; UMULL 9×0 → `Done` in cycle 3 with result 0.
  - Without the macro, both give `Done` in cycle 34.
